updown_counter_mod: RTL

Parametrised successor to the basic enable/direction counter. It adds:
- a programmable modulus (`MAX_VAL`);
- a per-cycle step size;
- a synchronous parallel load;
- three overflow modes: wrap, saturate and one-shot;
- terminal-count and wrap status outputs.

It serves as the general-purpose timebase, prescaler and event counter for the design, replacing fixed power-of-two counters.

---
 rtl/updown_counter_mod.sv | 64 ++++++
 1 files changed

// File: rtl/updown_counter_mod.sv
// updown_counter_mod: modulo up/down counter with step, load, wrap/saturate/one-shot modes
module updown_counter_mod #(
  parameter int WIDTH = 8,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic [WIDTH-1:0] step,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped,
  output logic             done
);
  localparam logic [WIDTH:0] MAXW = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAXC = WIDTH'(MAX_VAL);
  typedef enum logic {RUN, DONE} state_t;
  state_t state;
  logic [WIDTH:0] s_up, up_wrap, dn_sub, dn_wrap, nxt, term;
  logic up_ovf, dn_ovf, sat, one_shot, wrap_evt;
  // one extra bit keeps the sums and the modulus itself representable
  always_comb begin
    s_up = {1'b0, count} + {1'b0, step};
    up_wrap = s_up - (MAXW + 1'b1);
    dn_sub = {1'b0, count} - {1'b0, step};
    dn_wrap = {1'b0, count} + MAXW + 1'b1 - {1'b0, step};
    up_ovf = s_up > MAXW;
    dn_ovf = step > count;
    sat = mode == 2'b01 || mode == 2'b10;
    one_shot = mode == 2'b10;
    nxt = dir ? (up_ovf ? (sat ? MAXW : up_wrap) : s_up)
              : (dn_ovf ? (sat ? '0 : dn_wrap) : dn_sub);
    wrap_evt = !sat && (dir ? up_ovf : dn_ovf);
    term = dir ? MAXW : '0;
  end
  assign tc = dir ? count == MAXC : count == '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      wrapped <= 1'b0;
      done <= 1'b0;
      state <= RUN;
    end else if (load) begin
      count <= load_val > MAXC ? MAXC : load_val;
      wrapped <= 1'b0;
      done <= 1'b0;
      state <= RUN;
    end else begin
      wrapped <= 1'b0;
      if (state == RUN && en) begin
        count <= nxt[WIDTH-1:0];
        wrapped <= wrap_evt;
        if (one_shot && nxt == term) begin
          state <= DONE;
          done <= 1'b1;
        end
      end
    end
  end
endmodule
